// File: rtl/cross_win_pkg.sv
// Shared definitions for the cross-window controller: FSM encoding and counter sizing.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package cross_win_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int DEF_ROW = 30;
  localparam int DEF_COL = 30;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ROW_W = cnt_w(DEF_ROW);
  localparam int DEF_COL_W = cnt_w(DEF_COL);

endpackage

// File: rtl/vld_delay.sv
// Fixed-depth pipeline that carries a window-valid bit plus its sideband.
// Latency: DEPTH cycles (DEPTH >= 1).
// Backpressure: none; clr_i empties every stage on the next edge.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous flush,
//        d_i input word, q_o word delayed by DEPTH cycles.
module vld_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cross_win_ctrl.sv
// Sequences pixels into an external shift register and tags each 5-pixel cross window.
// Latency: shift_din 1 cycle after pix_in; win_vld 1+SHIFT_LAT cycles after the shifting pixel.
// Backpressure: none; pix_vld gaps stall all counters, pixels during FLUSH are dropped (err_ovf).
// Ports: vga_clk/rst_n clock and async active-low reset; sof, pix_in, pix_vld input stream;
//        shift_din/shift_din_vld to the shift register; win_vld, win_row, win_col, border
//        window tag; busy, frame_done, err_resync, err_ovf status pulses.
module cross_win_ctrl
  import cross_win_pkg::*;
#(
  parameter int ROW       = DEF_ROW,
  parameter int COL       = DEF_COL,
  parameter int SHIFT_LAT = 1
) (
  input  logic                    vga_clk,
  input  logic                    rst_n,
  input  logic                    sof,
  input  logic [7:0]              pix_in,
  input  logic                    pix_vld,
  output logic [7:0]              shift_din,
  output logic                    shift_din_vld,
  output logic                    win_vld,
  output logic [cnt_w(ROW)-1:0]   win_row,
  output logic [cnt_w(COL)-1:0]   win_col,
  output logic                    border,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_resync,
  output logic                    err_ovf
);

  localparam int RW = cnt_w(ROW);
  localparam int CW = cnt_w(COL);
  localparam int FW = cnt_w(COL + 2);
  localparam int BW = 3 + RW + CW;

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROW - 1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COL - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(COL);

  state_e        state_q, state_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] c_row_q, c_row_d;
  logic [CW-1:0] c_col_q, c_col_d;
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic [7:0]    shift_din_q, shift_din_d;
  logic          shift_vld_q, shift_vld_d;
  logic          resync_q, resync_d;
  logic          ovf_q, ovf_d;
  logic          frame_done_q, frame_done_d;

  logic          accept, flush_shift, win_gen, win_last, win_border;
  logic [BW-1:0] win_pre, win_dly;
  logic          dly_vld, dly_last, dly_border;
  logic [RW-1:0] dly_row;
  logic [CW-1:0] dly_col;

  // A sof always opens a frame, so a pixel arriving with it is accepted even from IDLE/FLUSH.
  assign accept      = pix_vld && (sof || state_q == ST_FILL || state_q == ST_RUN);
  assign flush_shift = !sof && (state_q == ST_FLUSH);
  // Windows come from shifts past the first COL+1 pixels: RUN acceptances plus every flush shift.
  assign win_gen     = !sof && ((state_q == ST_RUN && pix_vld) || state_q == ST_FLUSH);
  assign win_last    = (c_row_q == ROW_LAST) && (c_col_q == COL_LAST);
  assign win_border  = (c_row_q == '0) || (c_row_q == ROW_LAST) ||
                       (c_col_q == '0) || (c_col_q == COL_LAST);

  always_comb begin
    state_d      = state_q;
    fl_cnt_d     = fl_cnt_q;
    in_row_d     = sof ? '0 : in_row_q;
    in_col_d     = sof ? '0 : in_col_q;
    c_row_d      = sof ? '0 : c_row_q;
    c_col_d      = sof ? '0 : c_col_q;
    shift_din_d  = accept ? pix_in : 8'h00;
    shift_vld_d  = accept || flush_shift;
    resync_d     = sof && (state_q != ST_IDLE);
    ovf_d        = pix_vld && flush_shift;
    frame_done_d = dly_vld && dly_last;

    if (accept) begin
      if (in_col_d == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_d == ROW_LAST) ? '0 : in_row_d + 1'b1;
      end else begin
        in_col_d = in_col_d + 1'b1;
      end
    end

    if (win_gen) begin
      if (c_col_q == COL_LAST) begin
        c_col_d = '0;
        c_row_d = (c_row_q == ROW_LAST) ? '0 : c_row_q + 1'b1;
      end else begin
        c_col_d = c_col_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      // Accepting pixel (1,0) makes COL+1 resident; the next shift completes window (0,0).
      ST_FILL: if (accept && in_row_q == ROW_ONE && in_col_q == '0) state_d = ST_RUN;
      ST_RUN: begin
        if (accept && in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        fl_cnt_d = fl_cnt_q + 1'b1;
        if (fl_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // sof wins from any state: start (or restart) filling.
    if (sof) begin
      state_d  = ST_FILL;
      fl_cnt_d = '0;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_row_q     <= '0;
      in_col_q     <= '0;
      c_row_q      <= '0;
      c_col_q      <= '0;
      fl_cnt_q     <= '0;
      shift_din_q  <= '0;
      shift_vld_q  <= 1'b0;
      resync_q     <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      c_row_q      <= c_row_d;
      c_col_q      <= c_col_d;
      fl_cnt_q     <= fl_cnt_d;
      shift_din_q  <= shift_din_d;
      shift_vld_q  <= shift_vld_d;
      resync_q     <= resync_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // One stage matches the shift_din register, SHIFT_LAT more match the external shift register.
  // A resync flushes windows of the aborted frame still in flight.
  assign win_pre = {win_gen, win_last, win_border, c_row_q, c_col_q};

  vld_delay #(
    .W     (BW),
    .DEPTH (SHIFT_LAT + 1)
  ) u_vld_delay (
    .clk_i  (vga_clk),
    .rst_ni (rst_n),
    .clr_i  (resync_d),
    .d_i    (win_pre),
    .q_o    (win_dly)
  );

  assign {dly_vld, dly_last, dly_border, dly_row, dly_col} = win_dly;

  assign shift_din     = shift_din_q;
  assign shift_din_vld = shift_vld_q;
  assign win_vld       = dly_vld;
  assign win_row       = dly_row;
  assign win_col       = dly_col;
  assign border        = dly_border && dly_vld;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = frame_done_q;
  assign err_resync    = resync_q;
  assign err_ovf       = ovf_q;

endmodule

// File: tb/tb_cross_win_ctrl.sv
module tb_cross_win_ctrl;

  localparam int ROW = 30;
  localparam int COL = 30;
  localparam int LAT = 1;
  localparam int RW  = $clog2(ROW);
  localparam int CW  = $clog2(COL);

  logic          vga_clk = 1'b0;
  logic          rst_n;
  logic          sof;
  logic [7:0]    pix_in;
  logic          pix_vld;
  logic [7:0]    shift_din;
  logic          shift_din_vld;
  logic          win_vld;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          border;
  logic          busy;
  logic          frame_done;
  logic          err_resync;
  logic          err_ovf;

  typedef struct packed {
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          b;
  } win_t;

  win_t exp_q[$];
  bit   sb_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   t_first = 0;
  int   first_win_cyc, win_cnt, border_cnt, fd_cnt, rs_cnt, ovf_cnt;
  int   shift_cnt, zero_cnt, busy_cnt;

  cross_win_ctrl #(
    .ROW       (ROW),
    .COL       (COL),
    .SHIFT_LAT (LAT)
  ) dut (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .sof           (sof),
    .pix_in        (pix_in),
    .pix_vld       (pix_vld),
    .shift_din     (shift_din),
    .shift_din_vld (shift_din_vld),
    .win_vld       (win_vld),
    .win_row       (win_row),
    .win_col       (win_col),
    .border        (border),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_resync    (err_resync),
    .err_ovf       (err_ovf)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic logic [7:0] pix_val(input int k);
    return 8'((k % 255) + 1);
  endfunction

  task automatic clr_stats();
    first_win_cyc = -1; win_cnt = 0; border_cnt = 0; fd_cnt = 0; rs_cnt = 0;
    ovf_cnt = 0; shift_cnt = 0; zero_cnt = 0; busy_cnt = 0;
  endtask

  // Expected windows of one full frame, raster order, border from geometry.
  task automatic push_frame();
    win_t e;
    exp_q.delete();
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        e.r = RW'(r);
        e.c = CW'(c);
        e.b = (r == 0) || (r == ROW - 1) || (c == 0) || (c == COL - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor: pops one expected window per observed win_vld.
  task automatic sb_monitor();
    win_t e;
    forever begin
      @(negedge vga_clk);
      if (rst_n === 1'b1) begin
        if (busy === 1'b1) busy_cnt++;
        if (shift_din_vld === 1'b1) begin
          shift_cnt++;
          if (shift_din === 8'h00) zero_cnt++;
        end
        if (err_ovf === 1'b1) ovf_cnt++;
        if (err_resync === 1'b1) rs_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (win_vld === 1'b1) begin
          win_cnt++;
          if (border === 1'b1) border_cnt++;
          if (win_cnt == 1) first_win_cyc = cyc;
          if (sb_en) begin
            n_total++;
            if (exp_q.size() == 0) begin
              $display("FAIL sb_window: unexpected window row=%0d col=%0d, required none", win_row, win_col);
            end else begin
              e = exp_q.pop_front();
              if ({win_row, win_col, border} !== e)
                $display("FAIL sb_window: got row=%0d col=%0d border=%b, required row=%0d col=%0d border=%b",
                         win_row, win_col, border, e.r, e.c, e.b);
              else n_pass++;
            end
          end
        end
      end
    end
  endtask

  task automatic drive_frame(input bit gaps, input int npix, input bit sof_first,
                             input bit arm, input int tail);
    if (!sof_first) begin
      if (arm) begin clr_stats(); push_frame(); sb_en = 1'b1; end
      sof = 1'b1; pix_vld = 1'b0;
      step();
      sof = 1'b0;
    end
    for (int k = 0; k < npix; k++) begin
      if (gaps && k > 0) begin pix_vld = 1'b0; step(); end
      sof     = sof_first && (k == 0);
      pix_vld = 1'b1;
      pix_in  = pix_val(k);
      if (k == 0) t_first = cyc;
      step();
      sof = 1'b0;
      if (k == 0 && sof_first && arm) begin clr_stats(); push_frame(); sb_en = 1'b1; end
    end
    for (int t = 0; t < tail; t++) begin
      pix_vld = 1'b1; pix_in = 8'hAA;
      step();
    end
    pix_vld = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin step(); n++; end
    timed_out = (busy !== 1'b0);
    repeat (LAT + 4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sof = 1'b1; pix_vld = 1'b1; pix_in = 8'h5A;
    repeat (3) step();
    n_total++;
    if ({shift_din, shift_din_vld, win_vld, win_row, win_col, border, busy, frame_done, err_resync, err_ovf} !== '0)
      $display("FAIL reset_outputs: got %h, required all zero",
               {shift_din, shift_din_vld, win_vld, win_row, win_col, border, busy, frame_done, err_resync, err_ovf});
    else n_pass++;
    sof = 1'b0; pix_vld = 1'b0;
    rst_n = 1'b1;
    step();
    n_total++;
    if ({busy, shift_din_vld} !== 2'b00) $display("FAIL reset_release: busy,shift_vld=%b, required 00", {busy, shift_din_vld});
    else n_pass++;
  endtask

  task automatic test_no_sof();
    bit to;
    clr_stats();
    for (int k = 0; k < 20; k++) begin pix_vld = 1'b1; pix_in = pix_val(k); step(); end
    pix_vld = 1'b0;
    wait_idle(to);
    n_total++;
    if (shift_cnt !== 0) $display("FAIL no_sof_shift: %0d shifts, required 0", shift_cnt); else n_pass++;
    n_total++;
    if (busy_cnt !== 0) $display("FAIL no_sof_busy: busy seen %0d cycles, required 0", busy_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    drive_frame(1'b0, ROW * COL, 1'b0, 1'b1, 0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_flush: busy=%b, required 1", busy); else n_pass++;
    wait_idle(to);
    sb_en = 1'b0;
    n_total++;
    if (to) $display("FAIL b2b_idle: busy=%b after bound, required 0", busy); else n_pass++;
    n_total++;
    if (first_win_cyc - t_first !== 32 + LAT)
      $display("FAIL b2b_latency: %0d cycles, required %0d", first_win_cyc - t_first, 32 + LAT);
    else n_pass++;
    n_total++;
    if (win_cnt !== ROW * COL) $display("FAIL b2b_windows: %0d, required %0d", win_cnt, ROW * COL); else n_pass++;
    n_total++;
    if (border_cnt !== 116) $display("FAIL b2b_border: %0d, required 116", border_cnt); else n_pass++;
    n_total++;
    if (fd_cnt !== 1) $display("FAIL b2b_frame_done: %0d pulses, required 1", fd_cnt); else n_pass++;
    n_total++;
    if (shift_cnt !== ROW * COL + COL + 1) $display("FAIL b2b_shifts: %0d, required %0d", shift_cnt, ROW * COL + COL + 1); else n_pass++;
    n_total++;
    if (zero_cnt !== COL + 1) $display("FAIL b2b_flush_zero: %0d, required %0d", zero_cnt, COL + 1); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL b2b_sb_left: %0d windows missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_gaps();
    bit to;
    drive_frame(1'b1, ROW * COL, 1'b0, 1'b1, 0);
    wait_idle(to);
    sb_en = 1'b0;
    n_total++;
    if (to) $display("FAIL gaps_idle: busy=%b after bound, required 0", busy); else n_pass++;
    n_total++;
    if (win_cnt !== ROW * COL) $display("FAIL gaps_windows: %0d, required %0d", win_cnt, ROW * COL); else n_pass++;
    n_total++;
    if (fd_cnt !== 1) $display("FAIL gaps_frame_done: %0d pulses, required 1", fd_cnt); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL gaps_sb_left: %0d windows missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_resync();
    bit to;
    sb_en = 1'b0;
    drive_frame(1'b0, 450, 1'b0, 1'b0, 0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL resync_busy_mid: busy=%b, required 1", busy); else n_pass++;
    drive_frame(1'b0, ROW * COL, 1'b1, 1'b1, 0);
    wait_idle(to);
    sb_en = 1'b0;
    n_total++;
    if (to) $display("FAIL resync_idle: busy=%b after bound, required 0", busy); else n_pass++;
    n_total++;
    if (rs_cnt !== 1) $display("FAIL resync_pulse: %0d pulses, required 1", rs_cnt); else n_pass++;
    n_total++;
    if (first_win_cyc - t_first !== 32 + LAT)
      $display("FAIL resync_latency: %0d cycles, required %0d", first_win_cyc - t_first, 32 + LAT);
    else n_pass++;
    n_total++;
    if (win_cnt !== ROW * COL) $display("FAIL resync_windows: %0d, required %0d", win_cnt, ROW * COL); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL resync_sb_left: %0d windows missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    bit to;
    drive_frame(1'b0, ROW * COL, 1'b0, 1'b1, 40);
    wait_idle(to);
    sb_en = 1'b0;
    n_total++;
    if (to) $display("FAIL ovf_idle: busy=%b after bound, required 0", busy); else n_pass++;
    n_total++;
    if (ovf_cnt !== COL + 1) $display("FAIL ovf_pulses: %0d, required %0d", ovf_cnt, COL + 1); else n_pass++;
    n_total++;
    if (zero_cnt !== COL + 1) $display("FAIL ovf_flush_zero: %0d, required %0d", zero_cnt, COL + 1); else n_pass++;
    n_total++;
    if (shift_cnt !== ROW * COL + COL + 1) $display("FAIL ovf_shifts: %0d, required %0d", shift_cnt, ROW * COL + COL + 1); else n_pass++;
    n_total++;
    if (win_cnt !== ROW * COL) $display("FAIL ovf_windows: %0d, required %0d", win_cnt, ROW * COL); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    sb_en = 1'b0;
    drive_frame(1'b0, 500, 1'b0, 1'b0, 0);
    n_total++;
    if (shift_din_vld !== 1'b1) $display("FAIL rstmid_pre_shift: shift_din_vld=%b, required 1", shift_din_vld); else n_pass++;
    pix_vld = 1'b1; pix_in = pix_val(500);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({shift_din, shift_din_vld, win_vld, win_row, win_col, border, busy, frame_done, err_resync, err_ovf} !== '0)
      $display("FAIL rstmid_outputs: got %h, required all zero",
               {shift_din, shift_din_vld, win_vld, win_row, win_col, border, busy, frame_done, err_resync, err_ovf});
    else n_pass++;
    step();
    rst_n = 1'b1;
    clr_stats();
    for (int k = 0; k < 50; k++) begin pix_vld = 1'b1; pix_in = pix_val(k); step(); end
    pix_vld = 1'b0;
    wait_idle(to);
    n_total++;
    if (shift_cnt !== 0) $display("FAIL rstmid_shift: %0d shifts, required 0", shift_cnt); else n_pass++;
    n_total++;
    if (busy_cnt !== 0 || win_cnt !== 0)
      $display("FAIL rstmid_quiet: busy %0d cycles, %0d windows, required 0 and 0", busy_cnt, win_cnt);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; sof = 1'b0; pix_vld = 1'b0; pix_in = 8'h00;
    clr_stats();
    fork
      sb_monitor();
    join_none
    test_reset();
    test_no_sof();
    test_back_to_back();
    test_gaps();
    test_resync();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
